sram_mult_adder: RTL and testbench

SRAM_MULT_ADDER -- requirements
Module: sram_mult_adder

---
 rtl/sram_mult_adder.sv | 119 +++++++++++
 tb/tb_sram_mult_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mult_adder.sv
// -----------------------------------------------------------------------------
// sram_mult_adder
//   Three independent datapaths sharing one clock and one reset:
//     * a DEPTH x WIDTH scratchpad with registered write and combinational read
//     * a variable-precision unsigned multiplier with one cycle of latency
//     * a combinational unsigned adder (wrapping, or saturating with ADD_SAT_EN)
//
// Configuration macro:
//   ADD_SAT_EN  - when defined, add_c saturates to all-ones on carry-out;
//                 when undefined, add_c wraps modulo 2^WIDTH.
//
// Ports:
//   CLK         in   1      single clock, rising edge
//   clr_        in   1      asynchronous active-low reset
//   sram_in     in   WIDTH  scratchpad write data
//   sram_en     in   1      scratchpad write enable
//   selector_i  in   4      scratchpad write address
//   selector_o  in   4      scratchpad read address
//   sram_out    out  WIDTH  scratchpad read data (combinational)
//   mul_a/b     in   WIDTH  multiplier operands (unsigned)
//   mul_bits    in   4      multiplier precision select, N = mul_bits+1
//   mul_c       out  WIDTH  registered, truncated product
//   add_a/b     in   WIDTH  adder operands (unsigned)
//   add_c       out  WIDTH  combinational sum
// -----------------------------------------------------------------------------
module sram_mult_adder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             clr_,
  input  logic [WIDTH-1:0] sram_in,
  input  logic             sram_en,
  input  logic [3:0]       selector_i,
  input  logic [3:0]       selector_o,
  output logic [WIDTH-1:0] sram_out,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic [3:0]       mul_bits,
  output logic [WIDTH-1:0] mul_c,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mul_mask_s;
  logic [WIDTH-1:0] mul_d;
  logic [WIDTH-1:0] mul_q;

  // Next-state of the scratchpad: only the addressed entry may change.
  // Selectors that match no entry (>= DEPTH) simply hit nothing.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (sram_en && (selector_i == 4'(i))) ? sram_in : mem_q[i];
    end
  end

  // Scratchpad storage; reset clears every entry without waiting for CLK.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read as an AND-OR mux over stored entries, so an
  // out-of-range selector reads zero and a same-cycle write is not visible
  // until the edge that commits it.
  always_comb begin
    sram_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sram_out = sram_out | (mem_q[i] & {WIDTH{selector_o == 4'(i)}});
    end
  end

  // Operand mask keeps the low mul_bits+1 bits; the product is evaluated in a
  // WIDTH-bit context so the upper half is truncated by construction.
  always_comb begin
    mul_mask_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mul_mask_s[i] = (i <= int'(mul_bits)) ? 1'b1 : 1'b0;
    end
    mul_d = (mul_a & mul_mask_s) * (mul_b & mul_mask_s);
  end

  // Product register; reset discards whatever was in flight.
  always_ff @(posedge CLK or negedge clr_) begin
    if (!clr_) begin
      mul_q <= '0;
    end else begin
      mul_q <= mul_d;
    end
  end

  assign mul_c = mul_q;

`ifdef ADD_SAT_EN
  logic [WIDTH:0] add_sum_s;

  // Saturating adder: any carry-out clamps the result to all-ones.
  always_comb begin
    add_sum_s = {1'b0, add_a} + {1'b0, add_b};
    add_c     = add_sum_s[WIDTH] ? {WIDTH{1'b1}} : add_sum_s[WIDTH-1:0];
  end
`else
  // Wrapping adder: the WIDTH-bit context drops the carry-out.
  always_comb begin
    add_c = add_a + add_b;
  end
`endif

endmodule

// File: tb/tb_sram_mult_adder.sv
// -----------------------------------------------------------------------------
// tb_sram_mult_adder
//   Self-checking bench for sram_mult_adder: table-driven multiplier/adder
//   vectors with a product scoreboard, plus hand-written scratchpad and reset
//   sequences. Inputs change on the falling edge; outputs are sampled away
//   from the rising edge.
// -----------------------------------------------------------------------------
module tb_sram_mult_adder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             CLK;
  logic             clr_;
  logic [WIDTH-1:0] sram_in;
  logic             sram_en;
  logic [3:0]       selector_i;
  logic [3:0]       selector_o;
  logic [WIDTH-1:0] sram_out;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [3:0]       mul_bits;
  logic [WIDTH-1:0] mul_c;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_c;

  int tests;
  int fails;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  bits;
    logic [15:0] aa;
    logic [15:0] ab;
    logic [15:0] exp_mul;
    logic [15:0] exp_add;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] mul_sb [$];

  sram_mult_adder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .clr_       (clr_),
    .sram_in    (sram_in),
    .sram_en    (sram_en),
    .selector_i (selector_i),
    .selector_o (selector_o),
    .sram_out   (sram_out),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_bits   (mul_bits),
    .mul_c      (mul_c),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Pop one expected product and compare it with mul_c.
  task automatic check_mul(input string name);
    logic [15:0] e;
    if (mul_sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, mul_c=0x%04h", name, mul_c);
    end else begin
      e = mul_sb.pop_front();
      check(name, mul_c, e);
    end
  endtask

  // Reference product: mask to N = bits+1 low bits, keep low 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] bits);
    logic [31:0] m;
    logic [31:0] p;
    m = (32'd1 << (int'(bits) + 1)) - 32'd1;
    p = ({16'd0, a} & m) * ({16'd0, b} & m);
    return p[15:0];
  endfunction

  initial begin
    tests = 0;
    fails = 0;

`ifdef ADD_SAT_EN
    vecs[0] = '{16'h00FF, 16'h0003, 4'd15, 16'hFFFF, 16'h0002, 16'h02FD, 16'hFFFF};
    vecs[2] = '{16'h0100, 16'h0100, 4'd15, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
    vecs[6] = '{16'h00AB, 16'h0002, 4'd15, 16'hF000, 16'h1000, 16'h0156, 16'hFFFF};
`else
    vecs[0] = '{16'h00FF, 16'h0003, 4'd15, 16'hFFFF, 16'h0002, 16'h02FD, 16'h0001};
    vecs[2] = '{16'h0100, 16'h0100, 4'd15, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
    vecs[6] = '{16'h00AB, 16'h0002, 4'd15, 16'hF000, 16'h1000, 16'h0156, 16'h0000};
`endif
    vecs[1] = '{16'h00FF, 16'h0003, 4'd3,  16'h1234, 16'h1111, 16'h002D, 16'h2345};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 4'd0,  16'h7FFF, 16'h0001, 16'h0001, 16'h8000};
    vecs[5] = '{16'h1234, 16'h5678, 4'd7,  16'hFFFE, 16'h0001, 16'h1860, 16'hFFFF};

    clr_       = 1'b0;
    sram_in    = 16'h0000;
    sram_en    = 1'b0;
    selector_i = 4'd0;
    selector_o = 4'd0;
    mul_a      = 16'h0000;
    mul_b      = 16'h0000;
    mul_bits   = 4'd15;
    add_a      = 16'h0000;
    add_b      = 16'h0000;

    // Writes are ignored while reset is held, even across rising edges.
    sram_en    = 1'b1;
    selector_i = 4'd2;
    sram_in    = 16'hBEEF;
    mul_a      = 16'h0005;
    mul_b      = 16'h0007;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    sram_en  = 1'b0;
    selector_o = 4'd2;
    #1;
    check("rst_sram", sram_out, 16'h0000);
    check("rst_mul", mul_c, 16'h0000);
    mul_a = 16'h0000;
    mul_b = 16'h0000;
    clr_ = 1'b1;

    // Basic write/read; an unwritten neighbour still reads zero.
    @(negedge CLK);
    sram_en    = 1'b1;
    selector_i = 4'd3;
    sram_in    = 16'h1234;
    @(negedge CLK);
    sram_en    = 1'b0;
    selector_o = 4'd3;
    #1;
    check("wr_rd_a3", sram_out, 16'h1234);
    selector_o = 4'd4;
    #1;
    check("rd_a4", sram_out, 16'h0000);
    selector_o = 4'd2;
    #1;
    check("rst_wr_ignored", sram_out, 16'h0000);

    // With enable low, the edge must not disturb address 3.
    sram_in    = 16'h5555;
    selector_i = 4'd3;
    @(negedge CLK);
    selector_o = 4'd3;
    #1;
    check("no_en_hold", sram_out, 16'h1234);

    // Read-during-write on address 7: old value before edge, new after.
    sram_en    = 1'b1;
    selector_i = 4'd7;
    sram_in    = 16'h0011;
    @(negedge CLK);
    sram_in    = 16'h0022;
    selector_o = 4'd7;
    #1;
    check("rdw_before", sram_out, 16'h0011);
    @(posedge CLK);
    #1;
    check("rdw_after", sram_out, 16'h0022);
    @(negedge CLK);
    sram_en = 1'b0;

    // Multiplier/adder vectors with scoreboarded products. The scratchpad is
    // written concurrently to exercise independence.
    mul_sb.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      if (i > 0) check_mul($sformatf("mul_v%0d", i - 1));
      mul_a      = vecs[i].a;
      mul_b      = vecs[i].b;
      mul_bits   = vecs[i].bits;
      add_a      = vecs[i].aa;
      add_b      = vecs[i].ab;
      sram_en    = 1'b1;
      selector_i = 4'(8 + i);
      sram_in    = 16'hC000 + 16'(i);
      mul_sb.push_back(vecs[i].exp_mul);
      #1;
      check($sformatf("add_v%0d", i), add_c, vecs[i].exp_add);
    end
    @(negedge CLK);
    check_mul("mul_v6");
    sram_en    = 1'b0;
    selector_o = 4'd11;
    #1;
    check("indep_sram", sram_out, 16'hC003);

    // Randomised products against the reference model.
    for (int i = 0; i < 20; i++) begin
      mul_a    = 16'($urandom);
      mul_b    = 16'($urandom);
      mul_bits = 4'($urandom_range(0, 15));
      mul_sb.push_back(ref_mul(mul_a, mul_b, mul_bits));
      @(negedge CLK);
      check_mul($sformatf("mul_rand%0d", i));
    end

    // Asynchronous reset clears scratchpad and product with no clock edge.
    sram_en    = 1'b1;
    selector_i = 4'd5;
    sram_in    = 16'hAAAA;
    mul_a      = 16'h0010;
    mul_b      = 16'h0010;
    mul_bits   = 4'd15;
    @(negedge CLK);
    sram_en    = 1'b0;
    selector_o = 4'd5;
    #1;
    check("pre_clr_a5", sram_out, 16'hAAAA);
    check("pre_clr_mul", mul_c, 16'h0100);
    #1;
    clr_ = 1'b0;
    #1;
    check("async_clr_a5", sram_out, 16'h0000);
    check("async_clr_mul", mul_c, 16'h0000);
    // Release before the next edge; the product stays zero until that edge.
    #1;
    clr_ = 1'b1;
    #1;
    check("post_rel_mul", mul_c, 16'h0000);
    @(posedge CLK);
    #1;
    check("first_edge_mul", mul_c, 16'h0100);

    // Adder wrap/saturate at the carry boundary.
    add_a = 16'hFFFF;
    add_b = 16'h0000;
    #1;
    check("add_max_nocarry", add_c, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
